// File: rtl/tmon_pkg.sv
// Shared types and constants for threshold_monitor: compare-mode encoding,
// default threshold and the persistence-counter width helper.
package tmon_pkg;

  localparam logic [1:0] MODE_EQ = 2'b00;
  localparam logic [1:0] MODE_GE = 2'b01;
  localparam logic [1:0] MODE_LE = 2'b10;
  localparam logic [1:0] MODE_NE = 2'b11;

  typedef enum logic [1:0] {
    CMP_EQ = MODE_EQ,
    CMP_GE = MODE_GE,
    CMP_LE = MODE_LE,
    CMP_NE = MODE_NE
  } cmp_mode_e;

  localparam int TMON_DEFAULT_THRESHOLD = 10;

  // Counter must be able to hold the value PERSIST itself.
  function automatic int persist_cnt_w(input int persist);
    return $clog2(persist + 1);
  endfunction

endpackage

// File: rtl/tmon_channel.sv
// One monitored channel: programmable compare, persistence counter, match,
// rise pulse and sticky flag, plus the count snapshot when TMON_SNAPSHOT_EN is defined.
module tmon_channel
  import tmon_pkg::*;
#(
  parameter int               WIDTH             = 4,
  parameter logic [WIDTH-1:0] DEFAULT_THRESHOLD = WIDTH'(TMON_DEFAULT_THRESHOLD),
  parameter int               PERSIST           = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] count,
  input  logic             valid,
  input  logic             cfg_wr,
  input  logic [WIDTH-1:0] cfg_threshold,
  input  cmp_mode_e        cfg_mode,
  input  logic             clr_sticky,
  output logic             match,
  output logic             match_rise,
`ifdef TMON_SNAPSHOT_EN
  output logic [WIDTH-1:0] snap,
`endif
  output logic             sticky
);

  localparam int              CNTW      = persist_cnt_w(PERSIST);
  localparam logic [CNTW-1:0] PERSIST_C = CNTW'(PERSIST);

  logic [WIDTH-1:0] thr_q, thr_d;
  cmp_mode_e        mode_q, mode_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic             match_q, match_d;
  logic             rise_q, rise_d;
  logic             sticky_q, sticky_d;
  logic             raw;

  always_comb begin
    raw = 1'b0;
    case (mode_q)
      CMP_EQ:  raw = (count == thr_q);
      CMP_GE:  raw = (count >= thr_q);
      CMP_LE:  raw = (count <= thr_q);
      CMP_NE:  raw = (count != thr_q);
      default: raw = 1'b0;
    endcase

    thr_d  = thr_q;
    mode_d = mode_q;
    cnt_d  = cnt_q;
    // A config write restarts the channel and discards this cycle's sample.
    if (cfg_wr) begin
      thr_d  = cfg_threshold;
      mode_d = cfg_mode;
      cnt_d  = '0;
    end else if (valid) begin
      if (!raw) cnt_d = '0;
      else if (cnt_q != PERSIST_C) cnt_d = cnt_q + CNTW'(1);
    end

    match_d  = (cnt_d == PERSIST_C);
    rise_d   = match_d && !match_q;
    sticky_d = rise_d ? 1'b1 : (clr_sticky ? 1'b0 : sticky_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      thr_q    <= DEFAULT_THRESHOLD;
      mode_q   <= CMP_EQ;
      cnt_q    <= '0;
      match_q  <= 1'b0;
      rise_q   <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      thr_q    <= thr_d;
      mode_q   <= mode_d;
      cnt_q    <= cnt_d;
      match_q  <= match_d;
      rise_q   <= rise_d;
      sticky_q <= sticky_d;
    end
  end

`ifdef TMON_SNAPSHOT_EN
  logic [WIDTH-1:0] snap_q, snap_d;

  always_comb begin
    snap_d = rise_d ? count : snap_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) snap_q <= '0;
    else        snap_q <= snap_d;
  end

  assign snap = snap_q;
`endif

  assign match      = match_q;
  assign match_rise = rise_q;
  assign sticky     = sticky_q;

endmodule

// File: rtl/threshold_monitor.sv
// CH-channel threshold monitor: config write decode, per-channel instances and irq.
// Define TMON_SNAPSHOT_EN to add the snap_value output.
module threshold_monitor
  import tmon_pkg::*;
#(
  parameter int               WIDTH             = 4,
  parameter int               CH                = 2,
  parameter logic [WIDTH-1:0] DEFAULT_THRESHOLD = WIDTH'(TMON_DEFAULT_THRESHOLD),
  parameter int               PERSIST           = 1,
  localparam int              CHW               = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CH*WIDTH-1:0] count_in,
  input  logic                valid_in,
  input  logic                cfg_we,
  input  logic [CHW-1:0]      cfg_ch,
  input  logic [WIDTH-1:0]    cfg_threshold,
  input  logic [1:0]          cfg_mode,
  input  logic [CH-1:0]       clr_sticky,
  output logic [CH-1:0]       match,
  output logic [CH-1:0]       match_rise,
  output logic [CH-1:0]       sticky,
`ifdef TMON_SNAPSHOT_EN
  output logic [CH*WIDTH-1:0] snap_value,
`endif
  output logic                irq
);

  logic [CH-1:0] cfg_sel;
  logic          irq_q, irq_d;

  // Equality decode: an out-of-range cfg_ch selects no channel.
  for (genvar i = 0; i < CH; i++) begin : g_ch
    assign cfg_sel[i] = cfg_we && (int'(cfg_ch) == i);

    tmon_channel #(
      .WIDTH             (WIDTH),
      .DEFAULT_THRESHOLD (DEFAULT_THRESHOLD),
      .PERSIST           (PERSIST)
    ) u_ch (
      .clk           (clk),
      .rst_n         (rst_n),
      .count         (count_in[i*WIDTH +: WIDTH]),
      .valid         (valid_in),
      .cfg_wr        (cfg_sel[i]),
      .cfg_threshold (cfg_threshold),
      .cfg_mode      (cmp_mode_e'(cfg_mode)),
      .clr_sticky    (clr_sticky[i]),
      .match         (match[i]),
      .match_rise    (match_rise[i]),
`ifdef TMON_SNAPSHOT_EN
      .snap          (snap_value[i*WIDTH +: WIDTH]),
`endif
      .sticky        (sticky[i])
    );
  end

  always_comb begin
    irq_d = |sticky;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) irq_q <= 1'b0;
    else        irq_q <= irq_d;
  end

  assign irq = irq_q;

endmodule

// File: tb/tb_threshold_monitor.sv
// Directed testbench for threshold_monitor (WIDTH=4, PERSIST=2; CH=2 main
// instance plus a CH=3 instance for the out-of-range channel write).
module tb_threshold_monitor;
  import tmon_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  count_in;
  logic        valid_in;
  logic        cfg_we;
  logic        cfg_ch;
  logic [3:0]  cfg_threshold;
  logic [1:0]  cfg_mode;
  logic [1:0]  clr_sticky;
  logic [1:0]  match, match_rise, sticky;
  logic        irq;

  logic [11:0] count3;
  logic        cfg_we3;
  logic [1:0]  cfg_ch3;
  logic [2:0]  clr3;
  logic [2:0]  match3, rise3, sticky3;
  logic        irq3;
`ifdef TMON_SNAPSHOT_EN
  logic [7:0]  snap_value;
  logic [11:0] snap3;
`endif

  int n_asserts = 0;
  int n_fail    = 0;

  always #5 clk = ~clk;

  threshold_monitor #(.WIDTH(4), .CH(2), .DEFAULT_THRESHOLD(4'd10), .PERSIST(2)) dut (
    .clk(clk), .rst_n(rst_n), .count_in(count_in), .valid_in(valid_in),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_threshold(cfg_threshold),
    .cfg_mode(cfg_mode), .clr_sticky(clr_sticky), .match(match),
    .match_rise(match_rise), .sticky(sticky),
`ifdef TMON_SNAPSHOT_EN
    .snap_value(snap_value),
`endif
    .irq(irq)
  );

  threshold_monitor #(.WIDTH(4), .CH(3), .DEFAULT_THRESHOLD(4'd10), .PERSIST(2)) dut3 (
    .clk(clk), .rst_n(rst_n), .count_in(count3), .valid_in(valid_in),
    .cfg_we(cfg_we3), .cfg_ch(cfg_ch3), .cfg_threshold(cfg_threshold),
    .cfg_mode(cfg_mode), .clr_sticky(clr3), .match(match3),
    .match_rise(rise3), .sticky(sticky3),
`ifdef TMON_SNAPSHOT_EN
    .snap_value(snap3),
`endif
    .irq(irq3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; count_in = '0; valid_in = 1'b0; cfg_we = 1'b0; cfg_ch = 1'b0;
    cfg_threshold = '0; cfg_mode = MODE_EQ; clr_sticky = '0;
    count3 = '0; cfg_we3 = 1'b0; cfg_ch3 = '0; clr3 = '0;
    repeat (2) tick();
    chk("rst_match",  16'(match),      16'(2'b00));
    chk("rst_rise",   16'(match_rise), 16'(2'b00));
    chk("rst_sticky", 16'(sticky),     16'(2'b00));
    chk("rst_irq",    16'(irq),        16'(1'b0));
    rst_n = 1'b1;

    // ch0 = 10 (default threshold, EQ) for two valid samples
    count_in = {4'd0, 4'd10}; valid_in = 1'b1;
    tick(); chk("a_one_sample", 16'(match), 16'(2'b00));
    tick();
    chk("a_match",  16'(match),      16'(2'b01));
    chk("a_rise",   16'(match_rise), 16'(2'b01));
    chk("a_sticky", 16'(sticky),     16'(2'b01));
    chk("a_irq_lag", 16'(irq),       16'(1'b0));
    tick();
    chk("a_rise_once", 16'(match_rise), 16'(2'b00));
    chk("a_irq",       16'(irq),        16'(1'b1));

    // 9 breaks the run; two more 10s needed
    count_in = {4'd0, 4'd9};  tick(); chk("b_break",   16'(match), 16'(2'b00));
    count_in = {4'd0, 4'd10}; tick(); chk("b_partial", 16'(match), 16'(2'b00));
    tick();
    chk("b_rematch", 16'(match),      16'(2'b01));
    chk("b_rerise",  16'(match_rise), 16'(2'b01));

    // ch1: threshold 5, GE
    valid_in = 1'b0; cfg_we = 1'b1; cfg_ch = 1'b1; cfg_threshold = 4'd5; cfg_mode = MODE_GE;
    tick();
    cfg_we = 1'b0; valid_in = 1'b1; count_in = {4'd7, 4'd10};
    tick(); tick();
    chk("c_match",  16'(match),      16'(2'b11));
    chk("c_rise",   16'(match_rise), 16'(2'b10));
    chk("c_sticky", 16'(sticky),     16'(2'b11));
    count_in = {4'd3, 4'd10}; tick();
    chk("c_fall",       16'(match),  16'(2'b01));
    chk("c_sticky_hold", 16'(sticky), 16'(2'b11));

    // clear and set in the same cycle on ch0: set wins
    count_in = {4'd3, 4'd9};  tick(); chk("d_break", 16'(match), 16'(2'b00));
    count_in = {4'd3, 4'd10}; tick();
    clr_sticky = 2'b01; tick();
    chk("d_rise",      16'(match_rise), 16'(2'b01));
    chk("d_set_wins",  16'(sticky),     16'(2'b11));
    clr_sticky = 2'b00;

    // config write to ch0 while matched and valid
    cfg_we = 1'b1; cfg_ch = 1'b0; cfg_threshold = 4'd10; cfg_mode = MODE_EQ;
    tick();
    chk("e_cfg_clears_match", 16'(match),      16'(2'b00));
    chk("e_cfg_no_rise",      16'(match_rise), 16'(2'b00));
    chk("e_cfg_keeps_sticky", 16'(sticky),     16'(2'b11));
    cfg_we = 1'b0;
    tick(); chk("e_restart", 16'(match), 16'(2'b00));
    tick(); chk("e_rise",    16'(match_rise), 16'(2'b01));

    // clear alone while match stays high
    clr_sticky = 2'b01; tick();
    chk("f_clear",       16'(sticky), 16'(2'b10));
    chk("f_match_kept",  16'(match),  16'(2'b01));
    clr_sticky = 2'b00; tick();
    chk("f_no_reset", 16'(sticky), 16'(2'b10));
    clr_sticky = 2'b10; tick();
    chk("f_all_clear", 16'(sticky), 16'(2'b00));
    chk("f_irq_lag",   16'(irq),    16'(1'b1));
    clr_sticky = 2'b00; tick();
    chk("f_irq_low",   16'(irq),    16'(1'b0));

    // reset mid-persistence
    count_in = {4'd7, 4'd10}; tick();
    chk("g_pre_reset", 16'(match), 16'(2'b01));
    #2 rst_n = 1'b0;
    #1;
    chk("g_rst_match",  16'(match),      16'(2'b00));
    chk("g_rst_rise",   16'(match_rise), 16'(2'b00));
    chk("g_rst_irq",    16'(irq),        16'(1'b0));
    tick();
    rst_n = 1'b1;
    count_in = {4'd7, 4'd0};  tick(); tick();
    chk("g_cfg_lost", 16'(match), 16'(2'b00));
    count_in = {4'd10, 4'd0}; tick(); tick();
    chk("g_default_thr", 16'(match), 16'(2'b10));

`ifdef TMON_SNAPSHOT_EN
    cfg_we = 1'b1; cfg_ch = 1'b0; cfg_threshold = 4'd12; cfg_mode = MODE_GE;
    tick();
    cfg_we = 1'b0; count_in = {4'd10, 4'd13}; tick();
    count_in = {4'd10, 4'd14}; tick();
    chk("s_rise", 16'(match_rise), 16'(2'b01));
    chk("s_snap", 16'(snap_value), 16'({4'd10, 4'd14}));
    count_in = {4'd10, 4'd15}; tick();
    chk("s_hold", 16'(snap_value), 16'({4'd10, 4'd14}));
`endif

    // 3-channel instance: cfg_ch=3 is out of range
    count3 = {4'd10, 4'd10, 4'd10}; tick(); tick();
    chk("h_match3",  16'(match3),  16'(3'b111));
    chk("h_sticky3", 16'(sticky3), 16'(3'b111));
    cfg_we3 = 1'b1; cfg_ch3 = 2'd3; cfg_threshold = 4'd0; cfg_mode = MODE_NE;
    tick();
    chk("h_oor_match", 16'(match3), 16'(3'b111));
    chk("h_oor_rise",  16'(rise3),  16'(3'b000));
    cfg_ch3 = 2'd2; tick();
    chk("h_ch2_write", 16'(match3), 16'(3'b011));
    cfg_we3 = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
